// File: rtl/cpu_pkg.sv
// Shared widths, ALU/forwarding codes and EX-stage types for the CPU pipeline.
package cpu_pkg;

  localparam int WORD     = 32;
  localparam int REG_SIZE = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

  typedef struct packed {
    logic [WORD-1:0]     writeData;
    logic [WORD-1:0]     aluResult;
    logic [REG_SIZE-1:0] writeReg;
    logic                regWrite;
    logic                memWrite;
    logic                mem2reg;
    logic                zero;
    logic                branch;
  } exmem_t;

endpackage

// File: rtl/flopr.sv
// Resettable register of arbitrary width; clears synchronously on reset.
module flopr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= d;
  end

  assign q = q_q;

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per BUSY cycle, result held in DONE.
module mul_iter
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] product
);

  mul_state_t      state_q, state_d;
  logic [WORD-1:0] mcand_q, mplier_q, acc_q;
  logic [4:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= MUL_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = MUL_IDLE;
    end else begin
      case (state_q)
        MUL_IDLE: if (start) state_d = MUL_BUSY;
        MUL_BUSY: if (cnt_q == 5'(WORD-1)) state_d = MUL_DONE;
        default:  state_d = MUL_IDLE;
      endcase
    end
  end

  // Operands are captured at start so later forwarding changes cannot corrupt the product.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == MUL_IDLE && start && !kill) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == MUL_BUSY && !kill) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 5'd1;
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (!kill) begin
      busy = (state_q == MUL_IDLE && start) || (state_q == MUL_BUSY);
      done = (state_q == MUL_DONE);
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/execute.sv
// EX stage: operand forwarding, ALU, iterative multiplier and the EX/MEM register.
module execute
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD-1:0]     RD1E,
  input  logic [WORD-1:0]     RD2E,
  input  logic [WORD-1:0]     signImmE,
  input  logic [REG_SIZE-1:0] rtE,
  input  logic [REG_SIZE-1:0] rdE,
  input  logic                regWriteE,
  input  logic                mem2regE,
  input  logic                memWriteE,
  input  logic                branchE,
  input  logic                ALUSrcE,
  input  logic                regDstE,
  input  logic [2:0]          ALUControlE,
  input  logic [1:0]          forwardAE,
  input  logic [1:0]          forwardBE,
  input  logic [WORD-1:0]     resultW,
  input  logic                killE,
  output logic                stallE,
  output logic [WORD-1:0]     writeDataM,
  output logic [WORD-1:0]     ALUResultM,
  output logic [REG_SIZE-1:0] writeRegM,
  output logic                regWriteM,
  output logic                memWriteM,
  output logic                mem2regM,
  output logic                zeroM,
  output logic                branchM
);

  function automatic logic [WORD-1:0] fwd(input logic [1:0] sel, input logic [WORD-1:0] rf,
                                          input logic [WORD-1:0] w, input logic [WORD-1:0] m);
    case (sel)
      FWD_W:   return w;
      FWD_M:   return m;
      default: return rf;
    endcase
  endfunction

  logic [WORD-1:0] srcA, bF, srcB, aluRes, mulProd;
  logic            mulBusy, mulDone, take;
  exmem_t          exmem_d, exmem_q;

  assign srcA = fwd(forwardAE, RD1E, resultW, ALUResultM);
  assign bF   = fwd(forwardBE, RD2E, resultW, ALUResultM);
  assign srcB = ALUSrcE ? signImmE : bF;

  mul_iter u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (ALUControlE == ALU_MUL),
    .kill    (killE),
    .a       (srcA),
    .b       (srcB),
    .busy    (mulBusy),
    .done    (mulDone),
    .product (mulProd)
  );

  always_comb begin
    aluRes = '0;
    case (ALUControlE)
      ALU_AND: aluRes = srcA & srcB;
      ALU_OR:  aluRes = srcA | srcB;
      ALU_ADD: aluRes = srcA + srcB;
      ALU_SUB: aluRes = srcA - srcB;
      ALU_SLT: aluRes = {{(WORD-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      ALU_MUL: aluRes = mulDone ? mulProd : '0;
      default: aluRes = '0;
    endcase
  end

  assign stallE = mulBusy & ~reset;
  // A MUL only reaches this point un-stalled in its DONE cycle, so take covers both paths.
  assign take   = ~killE & ~mulBusy;

  always_comb begin
    exmem_d = '0;
    if (take) begin
      exmem_d.writeData = bF;
      exmem_d.aluResult = aluRes;
      exmem_d.writeReg  = regDstE ? rdE : rtE;
      exmem_d.regWrite  = regWriteE;
      exmem_d.memWrite  = memWriteE;
      exmem_d.mem2reg   = mem2regE;
      exmem_d.zero      = (aluRes == '0);
      exmem_d.branch    = branchE;
    end
  end

  flopr #(.W($bits(exmem_t))) u_exmem (
    .clk   (clk),
    .reset (reset),
    .d     (exmem_d),
    .q     (exmem_q)
  );

  assign writeDataM = exmem_q.writeData;
  assign ALUResultM = exmem_q.aluResult;
  assign writeRegM  = exmem_q.writeReg;
  assign regWriteM  = exmem_q.regWrite;
  assign memWriteM  = exmem_q.memWrite;
  assign mem2regM   = exmem_q.mem2reg;
  assign zeroM      = exmem_q.zero;
  assign branchM    = exmem_q.branch;

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the EX stage: a cycle-level reference model predicts stallE and EX/MEM.
module tb_execute;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, regWriteE, mem2regE, memWriteE, branchE, ALUSrcE, regDstE, killE;
  logic [31:0] RD1E, RD2E, signImmE, resultW;
  logic [4:0]  rtE, rdE;
  logic [2:0]  ALUControlE;
  logic [1:0]  forwardAE, forwardBE;
  logic        stallE, regWriteM, memWriteM, mem2regM, zeroM, branchM;
  logic [31:0] writeDataM, ALUResultM;
  logic [4:0]  writeRegM;

  execute dut (
    .clk(clk), .reset(reset), .RD1E(RD1E), .RD2E(RD2E), .signImmE(signImmE),
    .rtE(rtE), .rdE(rdE), .regWriteE(regWriteE), .mem2regE(mem2regE),
    .memWriteE(memWriteE), .branchE(branchE), .ALUSrcE(ALUSrcE), .regDstE(regDstE),
    .ALUControlE(ALUControlE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .resultW(resultW), .killE(killE), .stallE(stallE), .writeDataM(writeDataM),
    .ALUResultM(ALUResultM), .writeRegM(writeRegM), .regWriteM(regWriteM),
    .memWriteM(memWriteM), .mem2regM(mem2regM), .zeroM(zeroM), .branchM(branchM)
  );

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, resw;
    logic [4:0]  rt, rd;
    logic        rw, m2r, mw, br, alusrc, regdst, kill, rst;
    logic [2:0]  op;
    logic [1:0]  fa, fb;
  } stim_t;

  typedef struct packed {
    logic [31:0] wd, ar;
    logic [4:0]  wr;
    logic        rw, mw, m2r, z, br;
  } em_t;

  em_t  exp_q[$];
  logic stall_q[$];
  int   checks = 0;
  int   passed = 0;

  int          mdl_rem = 0;
  logic [31:0] mdl_prod = '0;
  em_t         mdl_em = '0;

  function automatic em_t capture(input stim_t s, input logic [31:0] bf, input logic [31:0] r);
    em_t e;
    e.wd  = bf;
    e.ar  = r;
    e.wr  = s.regdst ? s.rd : s.rt;
    e.rw  = s.rw;
    e.mw  = s.mw;
    e.m2r = s.m2r;
    e.z   = (r == 32'd0);
    e.br  = s.br;
    return e;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'b01) return w;
    if (sel == 2'b10) return m;
    return rf;
  endfunction

  task automatic step(input stim_t s);
    em_t         e;
    logic        st;
    logic [31:0] a, bf, b, r;
    @(posedge clk);
    #1;
    reset = s.rst; RD1E = s.rd1; RD2E = s.rd2; signImmE = s.imm; resultW = s.resw;
    rtE = s.rt; rdE = s.rd; regWriteE = s.rw; mem2regE = s.m2r; memWriteE = s.mw;
    branchE = s.br; ALUSrcE = s.alusrc; regDstE = s.regdst; killE = s.kill;
    ALUControlE = s.op; forwardAE = s.fa; forwardBE = s.fb;
    a  = pick(s.fa, s.rd1, s.resw, mdl_em.ar);
    bf = pick(s.fb, s.rd2, s.resw, mdl_em.ar);
    b  = s.alusrc ? s.imm : bf;
    e  = '0;
    st = 1'b0;
    if (s.rst || s.kill) begin
      mdl_rem = 0;
    end else if (mdl_rem > 0) begin
      mdl_rem--;
      if (mdl_rem == 0) e = capture(s, bf, mdl_prod);
      else              st = 1'b1;
    end else if (s.op == 3'b011) begin
      mdl_prod = a * b;
      mdl_rem  = WORD + 1;
      st       = 1'b1;
    end else begin
      case (s.op)
        3'b000:  r = a & b;
        3'b001:  r = a | b;
        3'b010:  r = a + b;
        3'b110:  r = a - b;
        3'b111:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: r = 32'd0;
      endcase
      e = capture(s, bf, r);
    end
    mdl_em = e;
    stall_q.push_back(st);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (stall_q.size() > 0) begin
      logic st;
      st = stall_q.pop_front();
      checks++;
      if (stallE === st) passed++;
      else $display("FAIL stallE t=%0t got=%b want=%b", $time, stallE, st);
    end
    if (exp_q.size() >= 2) begin
      em_t e, act;
      e   = exp_q.pop_front();
      act = '{writeDataM, ALUResultM, writeRegM, regWriteM, memWriteM, mem2regM, zeroM, branchM};
      checks++;
      if (act === e) passed++;
      else $display("FAIL exmem t=%0t got wd=%h ar=%h wr=%0d rw%b mw%b m2r%b z%b br%b want wd=%h ar=%h wr=%0d rw%b mw%b m2r%b z%b br%b",
                    $time, act.wd, act.ar, act.wr, act.rw, act.mw, act.m2r, act.z, act.br,
                    e.wd, e.ar, e.wr, e.rw, e.mw, e.m2r, e.z, e.br);
    end
  end

  function automatic stim_t blank();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic mul_op(input logic [31:0] x, input logic [31:0] y, input int kill_at,
                        input int rst_at);
    stim_t s;
    s = blank();
    s.op = 3'b011; s.rd1 = x; s.rd2 = y; s.rw = 1'b1; s.regdst = 1'b1; s.rd = 5'd9;
    step(s);
    for (int i = 1; i <= WORD + 1 && mdl_rem > 0; i++) begin
      s.rd1  = $urandom;
      s.rd2  = $urandom;
      s.kill = (i == kill_at);
      s.rst  = (i == rst_at);
      step(s);
    end
  endtask

  task automatic rand_step();
    stim_t s;
    s        = blank();
    s.rd1    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
    s.rd2    = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
    s.imm    = $urandom;
    s.resw   = $urandom;
    s.rt     = 5'($urandom);
    s.rd     = 5'($urandom);
    s.rw     = 1'($urandom);
    s.m2r    = 1'($urandom);
    s.mw     = 1'($urandom);
    s.br     = 1'($urandom);
    s.alusrc = 1'($urandom);
    s.regdst = 1'($urandom);
    s.fa     = 2'($urandom);
    s.fb     = 2'($urandom);
    s.op     = 3'($urandom);
    s.kill   = ($urandom_range(0, 15) == 0);
    s.rst    = ($urandom_range(0, 60) == 0);
    if (s.op == 3'b011) s.op = 3'b010;
    step(s);
  endtask

  initial begin
    stim_t s;
    reset = 1'b1; killE = 1'b0; RD1E = '0; RD2E = '0; signImmE = '0; resultW = '0;
    rtE = '0; rdE = '0; regWriteE = 0; mem2regE = 0; memWriteE = 0; branchE = 0;
    ALUSrcE = 0; regDstE = 0; ALUControlE = '0; forwardAE = '0; forwardBE = '0;

    s = blank(); s.rst = 1'b1; s.op = 3'b010; s.rd1 = 32'd4; s.rw = 1'b1;
    step(s); step(s);

    s = blank(); s.op = 3'b010; s.rd1 = 32'd5; s.rd2 = 32'd3; s.rw = 1'b1; s.rt = 5'd3;
    step(s);
    s = blank(); s.op = 3'b110; s.fa = 2'b10; s.rd1 = 32'd100; s.rd2 = 32'd2; s.rw = 1'b1;
    step(s);
    s = blank(); s.op = 3'b010; s.fb = 2'b01; s.resw = 32'd9; s.rd2 = 32'd1; s.mw = 1'b1;
    step(s);
    s = blank(); s.op = 3'b111; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1; s.rw = 1'b1;
    step(s);
    s = blank(); s.op = 3'b110; s.rd1 = 32'h1234; s.rd2 = 32'h1234; s.br = 1'b1;
    step(s);
    s = blank(); s.op = 3'b100; s.rd1 = 32'd7; s.rd2 = 32'd1; s.rw = 1'b1;
    step(s);

    mul_op(32'd7, 32'd6, 0, 0);
    mul_op(32'hFFFF_FFFF, 32'd2, 0, 0);
    s = blank(); s.op = 3'b001; s.fa = 2'b10; s.rd2 = 32'h100;
    step(s);

    mul_op(32'd7, 32'd6, 10, 0);
    s = blank(); step(s); step(s);

    mul_op(32'd123, 32'd456, 0, 5);
    s = blank(); s.op = 3'b010; s.rd1 = 32'd5; s.rd2 = 32'd3; s.rw = 1'b1;
    step(s);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0)
        mul_op($urandom, ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 9)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0, 0);
      else
        rand_step();
    end

    s = blank(); step(s); step(s);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
